// File: rtl/jk_excitation_driver_if.sv
// rtl/jk_excitation_driver_if.sv - target-word handshake between pattern source and JK excitation driver
interface jk_excitation_driver_if #(
    parameter int WIDTH = 4
);
    logic             tgt_valid;
    logic [WIDTH-1:0] tgt_data;
    logic             prefer_toggle;
    logic             tgt_ready;

    // Pattern source side: offers target words
    modport master (
        output tgt_valid,
        output tgt_data,
        output prefer_toggle,
        input  tgt_ready
    );

    // Driver side: accepts target words
    modport slave (
        input  tgt_valid,
        input  tgt_data,
        input  prefer_toggle,
        output tgt_ready
    );
endinterface

// File: rtl/jk_excitation_driver.sv
// rtl/jk_excitation_driver.sv - drives a bank of external JK flip-flops to a target word with retry
module jk_excitation_driver #(
    parameter int WIDTH     = 4,
    parameter int MAX_RETRY = 3
) (
    input  logic                  clock,
    input  logic                  rst,
    jk_excitation_driver_if.slave tgt,
    output logic [WIDTH-1:0]      j,
    output logic [WIDTH-1:0]      k,
    input  logic [WIDTH-1:0]      q_fb,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [WIDTH-1:0]      fail_mask
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        CHECK = 2'd2
    } state_t;

    localparam logic [3:0] RETRY_LIMIT = 4'(MAX_RETRY);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] j_q, j_d;
    logic [WIDTH-1:0] k_q, k_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic [WIDTH-1:0] fail_q, fail_d;
    logic [3:0]       attempt_q, attempt_d;
    logic [WIDTH-1:0] target_q, target_d;
    logic             policy_q, policy_d;

    // Per-bit excitation: HOLD where Q already matches, else TOGGLE or SET/RESET
    function automatic logic [2*WIDTH-1:0] excite(
        input logic [WIDTH-1:0] q,
        input logic [WIDTH-1:0] t,
        input logic             toggle
    );
        logic [WIDTH-1:0] jv;
        logic [WIDTH-1:0] kv;
        logic [WIDTH-1:0] diff;
        diff = q ^ t;
        if (toggle) begin
            jv = diff;
            kv = diff;
        end else begin
            jv = diff & t;
            kv = diff & ~t;
        end
        return {jv, kv};
    endfunction

    // Next-state and registered-output computation; j/k default to HOLD
    always_comb begin
        state_d   = state_q;
        j_d       = '0;
        k_d       = '0;
        done_d    = 1'b0;
        err_d     = 1'b0;
        fail_d    = fail_q;
        attempt_d = attempt_q;
        target_d  = target_q;
        policy_d  = policy_q;
        unique case (state_q)
            IDLE: begin
                if (tgt.tgt_valid) begin
                    target_d   = tgt.tgt_data;
                    policy_d   = tgt.prefer_toggle;
                    attempt_d  = '0;
                    fail_d     = '0;
                    {j_d, k_d} = excite(q_fb, tgt.tgt_data, tgt.prefer_toggle);
                    state_d    = DRIVE;
                end
            end
            DRIVE: begin
                state_d = CHECK;
            end
            CHECK: begin
                if (q_fb == target_q) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else if (attempt_q < RETRY_LIMIT) begin
                    attempt_d  = attempt_q + 4'd1;
                    {j_d, k_d} = excite(q_fb, target_q, policy_q);
                    state_d    = DRIVE;
                end else begin
                    err_d   = 1'b1;
                    fail_d  = q_fb ^ target_q;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset forces HOLD onto the bank immediately
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            j_q       <= '0;
            k_q       <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            fail_q    <= '0;
            attempt_q <= '0;
            target_q  <= '0;
            policy_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            j_q       <= j_d;
            k_q       <= k_d;
            done_q    <= done_d;
            err_q     <= err_d;
            fail_q    <= fail_d;
            attempt_q <= attempt_d;
            target_q  <= target_d;
            policy_q  <= policy_d;
        end
    end

    assign tgt.tgt_ready = (state_q == IDLE);
    assign busy          = (state_q != IDLE);
    assign j             = j_q;
    assign k             = k_q;
    assign done          = done_q;
    assign err           = err_q;
    assign fail_mask     = fail_q;

endmodule

// File: tb/tb_jk_excitation_driver.sv
// tb/tb_jk_excitation_driver.sv - scoreboard bench for jk_excitation_driver with a JK bank model
module tb_jk_excitation_driver;

    localparam int W = 4;

    logic         clock = 1'b0;
    logic         rst;
    logic [W-1:0] j, k, q_fb, fail_mask;
    logic         busy, done, err;

    logic [W-1:0] bank_q = '0;
    logic [W-1:0] load_val = '0;
    logic         load = 1'b0;
    logic [W-1:0] stuck0 = '0;

    int cyc = 0;
    int n_checks = 0;
    int n_pass = 0;

    typedef struct {
        logic         is_err;
        logic [W-1:0] mask;
        logic [W-1:0] q;
        int           lat;
        int           acc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    jk_excitation_driver_if #(.WIDTH(W)) ifc ();

    jk_excitation_driver #(.WIDTH(W), .MAX_RETRY(3)) dut (
        .clock     (clock),
        .rst       (rst),
        .tgt       (ifc),
        .j         (j),
        .k         (k),
        .q_fb      (q_fb),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .fail_mask (fail_mask)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // JK bank model with optional stuck-at-0 bits
    always @(posedge clock) begin
        logic [W-1:0] nq;
        for (int i = 0; i < W; i++) begin
            case ({j[i], k[i]})
                2'b00:   nq[i] = bank_q[i];
                2'b10:   nq[i] = 1'b1;
                2'b01:   nq[i] = 1'b0;
                default: nq[i] = ~bank_q[i];
            endcase
        end
        if (load) nq = load_val;
        bank_q <= nq & ~stuck0;
    end

    assign q_fb = bank_q;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    endtask

    // Scoreboard: each done/err pulse is matched against the oldest outstanding word
    always @(negedge clock) begin
        if (!rst && (done || err)) begin
            if (sb.size() == 0) begin
                chk("spurious_pulse", {30'd0, done, err}, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                chk("done", done, !mon_e.is_err);
                chk("err", err, mon_e.is_err);
                chk("fail_mask", fail_mask, mon_e.mask);
                chk("bank_q", q_fb, mon_e.q);
                chk("latency", cyc - mon_e.acc, mon_e.lat);
            end
        end
    end

    task automatic set_q(input logic [W-1:0] v);
        @(negedge clock);
        load_val = v;
        load = 1'b1;
        @(negedge clock);
        load = 1'b0;
    endtask

    // Offer one word; returns at the negedge inside its first DRIVE cycle
    task automatic send(input logic [W-1:0] t, input logic ptg, input logic e_err,
                        input logic [W-1:0] e_mask, input logic [W-1:0] e_q, input int e_lat);
        int n = 0;
        @(negedge clock);
        while (!ifc.tgt_ready && n < 20) begin
            @(negedge clock);
            n++;
        end
        if (!ifc.tgt_ready) chk("ready_timeout", 0, 1);
        ifc.tgt_valid     = 1'b1;
        ifc.tgt_data      = t;
        ifc.prefer_toggle = ptg;
        sb.push_back('{e_err, e_mask, e_q, e_lat, cyc + 1});
        @(negedge clock);
        ifc.tgt_valid = 1'b0;
    endtask

    // Wait for the scoreboard to empty; counts further cycles carrying excitation
    task automatic drain(output int drives);
        int n = 0;
        drives = 0;
        while (sb.size() != 0 && n < 40) begin
            @(negedge clock);
            n++;
            if ((j | k) != '0) drives++;
        end
        chk("drain_timeout", sb.size(), 0);
    endtask

    initial begin
        int drives;
        int n;
        rst = 1'b1;
        ifc.tgt_valid = 1'b0;
        ifc.tgt_data = '0;
        ifc.prefer_toggle = 1'b0;
        repeat (2) @(negedge clock);
        chk("rst_j", j, 0);
        chk("rst_ready", ifc.tgt_ready, 1);
        chk("rst_busy", busy, 0);
        rst = 1'b0;

        // Reset asserted mid-DRIVE clears excitation at once
        set_q(4'b0000);
        send(4'b1010, 1'b0, 1'b0, 4'b0000, 4'b1010, 2);
        chk("pre_rst_j", j, 4'b1010);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_j", j, 0);
        chk("mid_rst_k", k, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_err", err, 0);
        chk("mid_rst_fail_mask", fail_mask, 0);
        sb.delete();
        @(negedge clock);
        rst = 1'b0;
        #1;
        chk("post_rst_ready", ifc.tgt_ready, 1);
        chk("post_rst_busy", busy, 0);

        // SET/RESET path
        set_q(4'b0000);
        send(4'b0110, 1'b0, 1'b0, 4'b0000, 4'b0110, 2);
        chk("set_j", j, 4'b0110);
        chk("set_k", k, 4'b0000);
        chk("set_busy", busy, 1);
        @(negedge clock);
        chk("set_check_j", j, 0);
        chk("set_check_busy", busy, 1);
        drain(drives);

        // Toggle path
        set_q(4'b1100);
        send(4'b0101, 1'b1, 1'b0, 4'b0000, 4'b0101, 2);
        chk("tog_j", j, 4'b1001);
        chk("tog_k", k, 4'b1001);
        drain(drives);

        // No-change word still passes DRIVE and CHECK
        set_q(4'b1011);
        send(4'b1011, 1'b0, 1'b0, 4'b0000, 4'b1011, 2);
        chk("same_j", j, 0);
        chk("same_k", k, 0);
        drain(drives);
        chk("same_drives", drives, 0);

        // Stuck bit 2: four attempts then err
        stuck0 = 4'b0100;
        set_q(4'b0000);
        send(4'b0100, 1'b0, 1'b1, 4'b0100, 4'b0000, 8);
        chk("stuck_j2", j[2], 1);
        drain(drives);
        chk("stuck_drives", drives + 1, 4);
        stuck0 = 4'b0000;

        // Back-to-back with tgt_valid held; busy-time data changes ignored
        set_q(4'b0000);
        @(negedge clock);
        ifc.tgt_valid = 1'b1;
        ifc.tgt_data = 4'b0001;
        ifc.prefer_toggle = 1'b0;
        sb.push_back('{1'b0, 4'b0000, 4'b0001, 2, cyc + 1});
        @(negedge clock);
        ifc.tgt_data = 4'b1111;
        ifc.prefer_toggle = 1'b1;
        n = 0;
        while (!done && n < 20) begin
            @(negedge clock);
            n++;
        end
        chk("b2b_first_done", done, 1);
        chk("b2b_ready_in_done", ifc.tgt_ready, 1);
        ifc.tgt_data = 4'b0011;
        ifc.prefer_toggle = 1'b0;
        sb.push_back('{1'b0, 4'b0000, 4'b0011, 2, cyc + 1});
        @(negedge clock);
        ifc.tgt_valid = 1'b0;
        chk("b2b_second_j", j, 4'b0010);
        chk("b2b_second_k", k, 4'b0000);
        drain(drives);

        repeat (3) @(negedge clock);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
